// File: rtl/clock_disp_pkg.sv
// Shared constants, segment codes and types for the multiplexed clock display.
package clock_disp_pkg;

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned FIELD_W    = 8;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned DIV_W      = 16;

  // Active-low {g,f,e,d,c,b,a} patterns for digits 0..9
  localparam logic [SEG_W-1:0] SEG_DIGIT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  typedef logic [2:0] digit_idx_t;

  typedef struct packed {
    logic [FIELD_W-1:0] hour;
    logic [FIELD_W-1:0] minute;
    logic [FIELD_W-1:0] sec;
  } hms_t;

  function automatic logic [SEG_W-1:0] seg_encode(input logic [BCD_W-1:0] bcd);
    if (bcd > 4'd9) return SEG_BLANK;
    return SEG_DIGIT[bcd];
  endfunction

endpackage

// File: rtl/clock_display_scan_if.sv
// Time-in / display-out signal bundle between a time source and the display scanner.
interface clock_display_scan_if;
  import clock_disp_pkg::*;

  logic [FIELD_W-1:0] hour;
  logic [FIELD_W-1:0] minute;
  logic [FIELD_W-1:0] sec;
  logic [SEG_W-1:0]   seg_n;
  logic               dp_n;
  logic [NUM_DIGITS-1:0] an_n;

  modport master (output hour, minute, sec, input seg_n, dp_n, an_n);
  modport slave  (input hour, minute, sec, output seg_n, dp_n, an_n);
endinterface

// File: rtl/bin2bcd_2d.sv
// Combinational split of a binary value 0..99 into BCD tens and units.
module bin2bcd_2d
  import clock_disp_pkg::*;
(
  input  logic [FIELD_W-1:0] bin,
  output logic [BCD_W-1:0]   tens,
  output logic [BCD_W-1:0]   units
);

  assign tens  = BCD_W'(bin / 8'd10);
  assign units = BCD_W'(bin % 8'd10);

endmodule

// File: rtl/clock_display_scan.sv
// Six-digit HH:MM:SS multiplexed 7-segment scanner with tear-free frame snapshots.
// Optional `COLON_BLINK_EN: colon follows seconds parity instead of staying lit.
module clock_display_scan
  import clock_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [FIELD_W-1:0]    hour,
  input  logic [FIELD_W-1:0]    minute,
  input  logic [FIELD_W-1:0]    sec,
  output logic [SEG_W-1:0]      seg_n,
  output logic                  dp_n,
  output logic [NUM_DIGITS-1:0] an_n
);

  logic [DIV_W-1:0] div_q;
  digit_idx_t       idx_q;
  hms_t             snap_q;
  logic             load_q;

  logic [BCD_W-1:0] hour_t, hour_u, min_t, min_u, sec_t, sec_u;
  logic             div_wrap_c, frame_end_c;
  logic             hour_bad_c, min_bad_c, sec_bad_c;
  logic [BCD_W-1:0] digit_c;
  logic             dash_c;
  logic             colon_c;
  logic [SEG_W-1:0] seg_c;
  logic             dp_c;
  logic [NUM_DIGITS-1:0] an_c;

  bin2bcd_2d u_bcd_hour (.bin(snap_q.hour),   .tens(hour_t), .units(hour_u));
  bin2bcd_2d u_bcd_min  (.bin(snap_q.minute), .tens(min_t),  .units(min_u));
  bin2bcd_2d u_bcd_sec  (.bin(snap_q.sec),    .tens(sec_t),  .units(sec_u));

  assign div_wrap_c  = (div_q == DIV_W'(SCAN_DIV - 1));
  assign frame_end_c = div_wrap_c && (idx_q == digit_idx_t'(NUM_DIGITS - 1));

  assign hour_bad_c = (snap_q.hour   > 8'd23);
  assign min_bad_c  = (snap_q.minute > 8'd59);
  assign sec_bad_c  = (snap_q.sec    > 8'd59);

`ifdef COLON_BLINK_EN
  assign colon_c = snap_q.sec[0];
`else
  assign colon_c = 1'b0;
`endif

  // Digit selection for the current scan position
  always_comb begin
    digit_c = '0;
    dash_c  = 1'b0;
    dp_c    = 1'b1;
    case (idx_q)
      3'd0: begin digit_c = hour_t; dash_c = hour_bad_c; end
      3'd1: begin digit_c = hour_u; dash_c = hour_bad_c; dp_c = colon_c; end
      3'd2: begin digit_c = min_t;  dash_c = min_bad_c;  end
      3'd3: begin digit_c = min_u;  dash_c = min_bad_c;  dp_c = colon_c; end
      3'd4: begin digit_c = sec_t;  dash_c = sec_bad_c;  end
      3'd5: begin digit_c = sec_u;  dash_c = sec_bad_c;  end
      default: begin digit_c = '0; dash_c = 1'b0; end
    endcase
    seg_c = dash_c ? SEG_DASH : seg_encode(digit_c);
    an_c  = ~(NUM_DIGITS'(1) << (3'd5 - idx_q));
  end

  // First edge after reset only captures the snapshot; scanning starts on the next
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q  <= '0;
      idx_q  <= '0;
      snap_q <= '0;
      load_q <= 1'b1;
      seg_n  <= SEG_BLANK;
      dp_n   <= 1'b1;
      an_n   <= '1;
    end else if (load_q) begin
      snap_q <= '{hour: hour, minute: minute, sec: sec};
      load_q <= 1'b0;
    end else begin
      seg_n <= seg_c;
      dp_n  <= dp_c;
      an_n  <= an_c;
      if (div_wrap_c) begin
        div_q <= '0;
        idx_q <= (idx_q == digit_idx_t'(NUM_DIGITS - 1)) ? '0 : idx_q + 3'd1;
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
      if (frame_end_c) snap_q <= '{hour: hour, minute: minute, sec: sec};
    end
  end

endmodule

// File: tb/tb_clock_display_scan.sv
// Self-checking bench: frame-level display model plus directed literal checks.
module tb_clock_display_scan;

  localparam int unsigned DIV = 4;
  localparam int unsigned FRAME = 6 * DIV;

  localparam logic [6:0] CODE [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [5:0] LIT_AN  [6] = '{6'b011111, 6'b101111, 6'b110111,
                                         6'b111011, 6'b111101, 6'b111110};
  localparam logic [6:0] LIT_SEG [6] = '{7'b0100100, 7'b0110000, 7'b0010010,
                                         7'b0010000, 7'b0010010, 7'b0000000};

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic chk_en = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  clock_display_scan_if dif ();

  logic [6:0] seg1;
  logic       dp1;
  logic [5:0] an1;

  clock_display_scan #(.SCAN_DIV(DIV)) u_dut (
    .clk(clk), .resetn(resetn),
    .hour(dif.hour), .minute(dif.minute), .sec(dif.sec),
    .seg_n(dif.seg_n), .dp_n(dif.dp_n), .an_n(dif.an_n)
  );

  clock_display_scan #(.SCAN_DIV(1)) u_dut1 (
    .clk(clk), .resetn(resetn),
    .hour(dif.hour), .minute(dif.minute), .sec(dif.sec),
    .seg_n(seg1), .dp_n(dp1), .an_n(an1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: posedges since release decide the lit digit
  int sh, sm, ss, n;
  logic [6:0] e_seg;
  logic       e_dp;
  logic [5:0] e_an;

  always @(posedge clk or negedge resetn) begin : model
    int p, d, v, lim, dig;
    if (!resetn) begin
      n = 0; e_seg = BLANK; e_dp = 1'b1; e_an = 6'h3f;
    end else begin
      n++;
      if (n == 1) begin
        sh = int'(dif.hour); sm = int'(dif.minute); ss = int'(dif.sec);
      end else begin
        p   = n - 2;
        d   = (p / DIV) % 6;
        v   = (d < 2) ? sh : (d < 4) ? sm : ss;
        lim = (d < 2) ? 23 : 59;
        dig = (d % 2 == 0) ? v / 10 : v % 10;
        e_seg = (v > lim) ? DASH : CODE[dig % 10];
        e_an  = 6'h3f;
        e_an[5 - d] = 1'b0;
`ifdef COLON_BLINK_EN
        e_dp = (d == 1 || d == 3) ? 1'(ss % 2) : 1'b1;
`else
        e_dp = (d == 1 || d == 3) ? 1'b0 : 1'b1;
`endif
        if (p % FRAME == FRAME - 1) begin
          sh = int'(dif.hour); sm = int'(dif.minute); ss = int'(dif.sec);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_seg", 8'(dif.seg_n), 8'(e_seg));
      chk("model_dp",  8'(dif.dp_n),  8'(e_dp));
      chk("model_an",  8'(dif.an_n),  8'(e_an));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    dif.hour = 8'(h); dif.minute = 8'(m); dif.sec = 8'(s);
  endtask

  task automatic directed(input int f, input int d, input int c);
    logic [6:0] want;
    case (f)
      1: begin
        if (c == 0) begin
          chk("f1_an",  8'(dif.an_n),  8'(LIT_AN[d]));
          chk("f1_seg", 8'(dif.seg_n), 8'(LIT_SEG[d]));
        end
        if (d == 0 && c < 2) begin
          chk("div1_an",  8'(an1),  8'(LIT_AN[c]));
          chk("div1_seg", 8'(seg1), 8'(LIT_SEG[c]));
        end
      end
      2: begin
        if (d == 2 && c == 0) dif.sec = 8'd59;
        if (d == 1 && c == 0) chk("f2_dp_sec58", 8'(dif.dp_n), 8'd0);
        if (d == 5 && c == 3) chk("f2_sec_units_held8", 8'(dif.seg_n), 8'(7'b0000000));
      end
      3: begin
`ifdef COLON_BLINK_EN
        if (d == 1 && c == 0) chk("f3_dp_sec59", 8'(dif.dp_n), 8'd1);
`else
        if (d == 1 && c == 0) chk("f3_dp_sec59", 8'(dif.dp_n), 8'd0);
`endif
        if (d == 5 && c == 0) chk("f3_sec_units9", 8'(dif.seg_n), 8'(7'b0010000));
        if (d == 2 && c == 0) dif.minute = 8'd60;
      end
      4: begin
        if (c == 1 && d > 0) begin
          want = (d == 2 || d == 3) ? DASH : LIT_SEG[d == 5 ? 3 : d];
          chk("f4_min60", 8'(dif.seg_n), 8'(want));
        end
        if (d == 1 && c == 0) set_time(24, 7, 60);
      end
      5: begin
        if (d == 0 && c == 0) chk("f5_hour24_dash", 8'(dif.seg_n), 8'(DASH));
        if (d == 3 && c == 0) chk("f5_min_units7",  8'(dif.seg_n), 8'(7'b1111000));
        if (d == 5 && c == 0) chk("f5_sec60_dash",  8'(dif.seg_n), 8'(DASH));
        if (d == 1 && c == 0) set_time(9, 5, 31);
      end
      6: if (d == 1 && c == 0) set_time(0, 0, 0);
      7: if (d == 1 && c == 0) set_time(255, 59, 0);
      default: ;
    endcase
  endtask

  initial begin
    set_time(23, 59, 58);
    #1 resetn = 1'b0;
    chk_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst_an",  8'(dif.an_n),  8'(6'b111111));
      chk("rst_seg", 8'(dif.seg_n), 8'(BLANK));
      chk("rst_dp",  8'(dif.dp_n),  8'd1);
    end
    resetn = 1'b1;
    tick();
    chk("load_blank_an",  8'(dif.an_n), 8'(6'b111111));
    chk("load_blank_an1", 8'(an1),      8'(6'b111111));

    for (int f = 1; f <= 7; f++)
      for (int d = 0; d < 6; d++)
        for (int c = 0; c < DIV; c++) begin
          tick();
          directed(f, d, c);
        end

    for (int i = 0; i < 3 * DIV + 1; i++) tick();
    chk("pre_rst_idx3", 8'(dif.an_n), 8'(LIT_AN[3]));
    #2 resetn = 1'b0;
    #1;
    chk("midrst_an",  8'(dif.an_n),  8'(6'b111111));
    chk("midrst_seg", 8'(dif.seg_n), 8'(BLANK));
    chk("midrst_dp",  8'(dif.dp_n),  8'd1);
    tick();
    resetn = 1'b1;
    tick();
    chk("post_rst_load", 8'(dif.an_n), 8'(6'b111111));
    tick();
    chk("post_rst_idx0_an",  8'(dif.an_n),  8'(LIT_AN[0]));
    chk("post_rst_idx0_seg", 8'(dif.seg_n), 8'(DASH));
    for (int i = 0; i < FRAME; i++) tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clock_display_scan.md
CLOCK_DISPLAY_SCAN -- requirements
Module: clock_display_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4, giving clk cycles each digit stays lit; legal range 1..65535.
REQ-002 SHALL have port clk  input  1  single system clock; all flops on rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port hour  input  8  binary hours from the time counter, legal range 0..23.
REQ-005 SHALL have port minute  input  8  binary minutes, legal range 0..59.
REQ-006 SHALL have port sec  input  8  binary seconds, legal range 0..59.
REQ-007 SHALL have port seg_n  output  7  active-low segments ordered {g,f,e,d,c,b,a}.
REQ-008 SHALL have port dp_n  output  1  active-low decimal point, used as the colon.
REQ-009 SHALL have port an_n  output  6  active-low digit enables; an_n[5] is hour tens and an_n[0] is seconds units.

Function
REQ-010 SHALL keep a divider counting 0..SCAN_DIV-1 that wraps to 0 at SCAN_DIV-1.
REQ-011 SHALL keep digit index 0..5 that advances by one when the divider wraps, and wraps from 5 to 0.
REQ-012 SHALL load the hour/minute/sec snapshot registers on the first clock edge after reset release and on each index 5->0 wrap; the display SHALL use only the snapshot (tear-free).
REQ-013 SHALL split each snapshot field into tens and units through bin2bcd_2d.
REQ-014 SHALL display the digit order: index 0 hour tens, 1 hour units, 2 minute tens, 3 minute units, 4 sec tens, 5 sec units.
REQ-015 SHALL drive only an_n[5-index] low; the other five an_n bits SHALL be 1.
REQ-016 SHALL use these seg_n codes for digits 0-9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
REQ-017 SHALL show dash 0111111 on both digits of a field when that field is out of range (hour>23, minute>59, sec>59).
REQ-018 SHALL register seg_n, dp_n and an_n so they reflect the index and snapshot with exactly one clk of latency.
REQ-019 SHALL hold dp_n at 1 except at index 1 and index 3, where its value is set by REQ-024/025.
REQ-020 SHALL show digit index 0 on the outputs in the second cycle after reset release, when SCAN_DIV=1.

Reset
REQ-021 SHALL make asserted resetn force an_n=111111, seg_n=1111111 and dp_n=1 immediately, without waiting for clk.
REQ-022 SHALL make asserted resetn clear the divider, the index and the snapshots to 0, and set the load flag to 1.
REQ-023 SHALL make a reset asserted mid-frame abandon the frame; scanning SHALL restart at index 0 after release.

Configuration
REQ-024 With COLON_BLINK_EN defined, dp_n SHALL be 0 at index 1 and index 3 only when snapshot sec is even, and 1 when it is odd.
REQ-025 Without COLON_BLINK_EN, dp_n SHALL always be 0 at index 1 and index 3.

Structure
REQ-026 SHALL get the following from package clock_disp_pkg: the NUM_DIGITS=6 constant, the ten digit segment codes, SEG_DASH, SEG_BLANK and the digit-index typedef.
REQ-027 SHALL instantiate sub-module bin2bcd_2d three times; bin2bcd_2d is combinational, takes 8-bit input 0..99 and gives 4-bit tens and 4-bit units; it is undefined above 99 and is masked by REQ-017.

Verification
REQ-028 SHALL cover: hold resetn low for 10 cycles -> an_n=111111, seg_n=1111111, dp_n=1 throughout.
REQ-029 SHALL cover: hour=23, minute=59, sec=58, SCAN_DIV=4 -> each of an_n=011111, 101111, 110111, 111011, 111101, 111110 is held 4 cycles, with seg_n 0100100, 0110000, 0010010, 0010000, 0010010, 0000000.
REQ-030 SHALL cover: sec changes 8->9 while index is 2 -> the rest of the frame shows 8 (0000000); the next frame shows 9 (0010000).
REQ-031 SHALL cover: minute=60 -> index 2 and index 3 show 0111111, while hour and sec digits stay correct.
REQ-032 SHALL cover, with COLON_BLINK_EN: sec=58 -> dp_n=0 at index 1 and 3; sec=59 in the next frame -> dp_n=1. Without the macro -> dp_n=0 at index 1 and 3 in both frames.
REQ-033 SHALL cover: resetn pulsed low while index=3 -> outputs blank in the same cycle; after release the scan restarts at an_n=011111.
